// File: rtl/pixel_fifo_pkg.sv
// Shared pixel-path helpers: parameter legality checks and byte reversal.
// Latency: n/a (functions only).
// Backpressure: n/a.
package pixel_fifo_pkg;

  // Widest pixel word any pixel-path block may use with byte_rev.
  localparam int PIX_MAX_W          = 1024;
  localparam int PIX_DEPTH_LOG2_MIN = 2;
  localparam int PIX_DEPTH_LOG2_MAX = 10;

  // Word width must be whole bytes and fit the byte-reverse helper.
  function automatic bit data_w_ok(input int w);
    return (w > 0) && ((w % 8) == 0) && (w <= PIX_MAX_W);
  endfunction

  function automatic bit depth_log2_ok(input int dl2);
    return (dl2 >= PIX_DEPTH_LOG2_MIN) && (dl2 <= PIX_DEPTH_LOG2_MAX);
  endfunction

  // Threshold of 2**dl2 is legal: almost_full then tracks wrfull.
  function automatic bit afull_th_ok(input int th, input int dl2);
    return (th >= 1) && (th <= (1 << dl2));
  endfunction

  // Reverses the lowest nbytes bytes of d; bytes above nbytes come back zero.
  function automatic logic [PIX_MAX_W-1:0] byte_rev(input logic [PIX_MAX_W-1:0] d,
                                                    input int nbytes);
    logic [PIX_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_MAX_W / 8; i++) begin
      if (i < nbytes) begin
        r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_pixel_ram.sv
// Simple dual-port storage for the pixel FIFO, no reset on contents.
// Latency: write lands on the clock edge; read data registered 1 cycle after rd_en.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module fifo_pixel_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first port: a same-address write (full FIFO, read+write) returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_pixel_sc.sv
// Single-clock pixel FIFO with optional byte swap on the read word and sticky ovf/udf.
// Latency: q valid 1 cycle after an accepted read; flags/usedw update on the edge after requests.
// Backpressure: writes dropped (ovf) when full without a same-cycle read; reads ignored (udf) when empty.
module fifo_pixel_sc
  import pixel_fifo_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 6,
  parameter int AFULL_TH   = 56
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  swap_en,
  input  logic [DATA_W-1:0]     data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_W-1:0]     q,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  ovf,
  output logic                  udf
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_AFULL = (DEPTH_LOG2+1)'(AFULL_TH);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("fifo_pixel_sc: DATA_W must be a non-zero multiple of 8");
  end
  if (!depth_log2_ok(DEPTH_LOG2)) begin : g_bad_depth
    $error("fifo_pixel_sc: DEPTH_LOG2 out of range");
  end
  if (!afull_th_ok(AFULL_TH, DEPTH_LOG2)) begin : g_bad_afull
    $error("fifo_pixel_sc: AFULL_TH out of range");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [DEPTH_LOG2:0]   usedw_nxt;
  logic [DATA_W-1:0]     ram_dat;
  logic [DATA_W-1:0]     ram_rev;
  logic                  q_vld;
  logic                  q_swap;

  // Request acceptance and next word count; a flush suppresses both ports.
  always_comb begin
    rd_acc    = rdreq & ~rdempty;
    wr_acc    = wrreq & (~wrfull | rd_acc);
    rd_fire   = rd_acc & ~sclr;
    wr_fire   = wr_acc & ~sclr;
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc) begin
      usedw_nxt = usedw + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      usedw_nxt = usedw - CNT_ONE;
    end
  end

  // Pointers, count, registered flags and sticky error bits.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      rdempty     <= 1'b1;
      wrfull      <= 1'b0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else if (sclr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      rdempty     <= 1'b1;
      wrfull      <= 1'b0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      usedw       <= usedw_nxt;
      rdempty     <= (usedw_nxt == '0);
      wrfull      <= (usedw_nxt == CNT_FULL);
      almost_full <= (usedw_nxt >= CNT_AFULL);
      if (wrreq && wrfull && !rd_acc) begin
        ovf <= 1'b1;
      end
      if (rdreq && rdempty) begin
        udf <= 1'b1;
      end
    end
  end

  // Remember whether q holds a real read and which byte order it was read with.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      q_vld  <= 1'b0;
      q_swap <= 1'b0;
    end else if (rd_fire) begin
      q_vld  <= 1'b1;
      q_swap <= swap_en;
    end
  end

  fifo_pixel_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_dat  (data),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_dat  (ram_dat)
  );

  // The RAM has no reset, so q is forced to zero until the first read after aclr.
  always_comb begin
    ram_rev = DATA_W'(byte_rev(PIX_MAX_W'(ram_dat), DATA_W / 8));
    q       = '0;
    if (q_vld) begin
      q = q_swap ? ram_rev : ram_dat;
    end
  end

endmodule

// File: tb/tb_fifo_pixel_sc.sv
module tb_fifo_pixel_sc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_aclr, a_sclr, a_swap_en, a_wrreq, a_rdreq;
  logic [63:0] a_data, a_q;
  logic        a_rdempty, a_wrfull, a_almost_full, a_ovf, a_udf;
  logic [6:0]  a_usedw;

  // Small instance: 24-bit words, depth 4, threshold 3
  logic        b_aclr, b_sclr, b_swap_en, b_wrreq, b_rdreq;
  logic [23:0] b_data, b_q;
  logic        b_rdempty, b_wrfull, b_almost_full, b_ovf, b_udf;
  logic [2:0]  b_usedw;

  int checks = 0;
  int errors = 0;

  fifo_pixel_sc u_dut (
    .clk(clk), .aclr(a_aclr), .sclr(a_sclr), .swap_en(a_swap_en),
    .data(a_data), .wrreq(a_wrreq), .rdreq(a_rdreq), .q(a_q),
    .rdempty(a_rdempty), .wrfull(a_wrfull), .almost_full(a_almost_full),
    .usedw(a_usedw), .ovf(a_ovf), .udf(a_udf)
  );

  fifo_pixel_sc #(.DATA_W(24), .DEPTH_LOG2(2), .AFULL_TH(3)) u_dut24 (
    .clk(clk), .aclr(b_aclr), .sclr(b_sclr), .swap_en(b_swap_en),
    .data(b_data), .wrreq(b_wrreq), .rdreq(b_rdreq), .q(b_q),
    .rdempty(b_rdempty), .wrfull(b_wrfull), .almost_full(b_almost_full),
    .usedw(b_usedw), .ovf(b_ovf), .udf(b_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] v;
    logic [23:0] vq [4];

    a_aclr = 1'b1; a_sclr = 1'b0; a_swap_en = 1'b0; a_wrreq = 1'b0; a_rdreq = 1'b0; a_data = '0;
    b_aclr = 1'b1; b_sclr = 1'b0; b_swap_en = 1'b0; b_wrreq = 1'b0; b_rdreq = 1'b0; b_data = '0;
    #3;
    chk("rst_q",       a_q,           64'h0);
    chk("rst_usedw",   a_usedw,       64'h0);
    chk("rst_rdempty", a_rdempty,     64'h1);
    chk("rst_wrfull",  a_wrfull,      64'h0);
    chk("rst_afull",   a_almost_full, 64'h0);
    chk("rst_ovf",     a_ovf,         64'h0);
    chk("rst_udf",     a_udf,         64'h0);
    chk("rst24_q",     b_q,           64'h0);
    chk("rst24_empty", b_rdempty,     64'h1);
    tick; tick;
    a_aclr = 1'b0; b_aclr = 1'b0;
    tick;

    // Byte swap on read
    a_swap_en = 1'b1; a_data = 64'h0102030405060708; a_wrreq = 1'b1;
    tick; a_wrreq = 1'b0;
    chk("swap_usedw1",   a_usedw,   64'd1);
    chk("swap_notempty", a_rdempty, 64'h0);
    a_rdreq = 1'b1;
    tick; a_rdreq = 1'b0;
    chk("swap_q",      a_q,       64'h0807060504030201);
    chk("swap_usedw0", a_usedw,   64'd0);
    chk("swap_empty",  a_rdempty, 64'h1);

    // Pass-through
    a_swap_en = 1'b0; a_data = 64'h1122334455667788; a_wrreq = 1'b1;
    tick; a_wrreq = 1'b0; a_rdreq = 1'b1;
    tick; a_rdreq = 1'b0;
    chk("pass_q", a_q, 64'h1122334455667788);

    // Read+write on empty: write taken, read ignored, udf set
    a_data = 64'hAAAABBBBCCCCDDDD; a_wrreq = 1'b1; a_rdreq = 1'b1;
    tick; a_wrreq = 1'b0; a_rdreq = 1'b0;
    chk("emptyrw_udf",   a_udf,     64'h1);
    chk("emptyrw_usedw", a_usedw,   64'd1);
    chk("emptyrw_q",     a_q,       64'h1122334455667788);
    chk("emptyrw_nempt", a_rdempty, 64'h0);
    a_rdreq = 1'b1;
    tick; a_rdreq = 1'b0;
    chk("emptyrw_rdq",   a_q,     64'hAAAABBBBCCCCDDDD);
    chk("udf_sticky",    a_udf,   64'h1);
    chk("emptyrw_used0", a_usedw, 64'd0);
    a_sclr = 1'b1;
    tick; a_sclr = 1'b0;
    chk("sclr_udf", a_udf, 64'h0);
    chk("sclr_q",   a_q,   64'hAAAABBBBCCCCDDDD);

    // Fill to full, almost_full threshold at 56
    a_wrreq = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_data = 64'(i);
      tick;
      chk("fill_usedw", a_usedw, 64'(i + 1));
      chk("fill_afull", a_almost_full, 64'((i + 1) >= 56));
    end
    chk("fill_wrfull", a_wrfull, 64'h1);
    a_data = 64'h999;
    tick; a_wrreq = 1'b0;
    chk("ovf_set",    a_ovf,    64'h1);
    chk("ovf_usedw",  a_usedw,  64'd64);
    chk("ovf_wrfull", a_wrfull, 64'h1);

    // Drain: overflowed word must not appear
    a_rdreq = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick;
      chk("drain_q", a_q, 64'(i));
    end
    a_rdreq = 1'b0;
    chk("drain_empty",  a_rdempty, 64'h1);
    chk("drain_usedw",  a_usedw,   64'd0);
    chk("ovf_sticky",   a_ovf,     64'h1);
    chk("drain_afull",  a_almost_full, 64'h0);

    // Refill, then simultaneous read+write while full
    a_wrreq = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_data = 64'(i);
      tick;
    end
    chk("refill_full", a_wrfull, 64'h1);
    a_rdreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_data = 64'(100 + k);
      tick;
      chk("fullrw_q",     a_q,      64'(k));
      chk("fullrw_usedw", a_usedw,  64'd64);
      chk("fullrw_full",  a_wrfull, 64'h1);
    end
    a_wrreq = 1'b0; a_rdreq = 1'b0;
    chk("fullrw_ovf_kept", a_ovf, 64'h1);

    // Synchronous flush
    a_sclr = 1'b1;
    tick; a_sclr = 1'b0;
    chk("flush_usedw", a_usedw,  64'd0);
    chk("flush_empty", a_rdempty, 64'h1);
    chk("flush_full",  a_wrfull,  64'h0);
    chk("flush_ovf",   a_ovf,     64'h0);
    a_wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = 64'(200 + i);
      tick;
    end
    chk("five_usedw", a_usedw, 64'd5);
    // sclr wins over both requests
    a_sclr = 1'b1; a_rdreq = 1'b1;
    tick; a_sclr = 1'b0; a_wrreq = 1'b0; a_rdreq = 1'b0;
    chk("sclr5_usedw", a_usedw,       64'd0);
    chk("sclr5_empty", a_rdempty,     64'h1);
    chk("sclr5_afull", a_almost_full, 64'h0);
    chk("sclr5_ovf",   a_ovf,         64'h0);
    chk("sclr5_udf",   a_udf,         64'h0);
    chk("sclr5_q",     a_q,           64'd9);

    // Async clear mid-cycle with words in flight
    a_data = 64'h55; a_wrreq = 1'b1;
    tick; a_wrreq = 1'b0; a_rdreq = 1'b1;
    tick; a_rdreq = 1'b0;
    chk("pre_aclr_q", a_q, 64'h55);
    a_wrreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = 64'(96 + i);
      tick;
    end
    a_wrreq = 1'b0;
    #2;
    a_aclr = 1'b1;
    #1;
    chk("aclr_q",     a_q,       64'h0);
    chk("aclr_usedw", a_usedw,   64'd0);
    chk("aclr_empty", a_rdempty, 64'h1);
    #2;
    a_aclr = 1'b0;
    tick;
    a_data = 64'h77; a_wrreq = 1'b1;
    tick; a_wrreq = 1'b0; a_rdreq = 1'b1;
    tick; a_rdreq = 1'b0;
    chk("post_aclr_q",     a_q,     64'h77);
    chk("post_aclr_usedw", a_usedw, 64'd0);

    // 24-bit instance: pass-through and pointer wrap
    for (int k = 0; k < 10; k++) begin
      v = 24'hA5C300 + 24'(k * 37);
      b_data = v; b_wrreq = 1'b1;
      tick; b_wrreq = 1'b0; b_rdreq = 1'b1;
      tick; b_rdreq = 1'b0;
      chk("w24_q", 64'(b_q), 64'(v));
    end
    chk("w24_empty", b_rdempty, 64'h1);
    b_wrreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vq[i] = 24'h123456 + 24'(i * 4097);
      b_data = vq[i];
      tick;
      if (i == 2) begin
        chk("w24_afull3", b_almost_full, 64'h1);
        chk("w24_nfull3", b_wrfull,      64'h0);
      end
    end
    chk("w24_full",  b_wrfull, 64'h1);
    chk("w24_used4", b_usedw,  64'd4);
    b_data = 24'hFFFFFF;
    tick; b_wrreq = 1'b0;
    chk("w24_ovf", b_ovf, 64'h1);
    b_rdreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("w24_drain_q", 64'(b_q), 64'(vq[i]));
    end
    b_rdreq = 1'b0;
    chk("w24_drain_empty", b_rdempty, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pixel_sc.md
FIFO_PIXEL_SC -- requirements
Module: fifo_pixel_sc

Interface
REQ-001 Parameter DATA_W, default 64: pixel word width in bits; SHALL be a non-zero multiple of 8.
REQ-002 Parameter DEPTH_LOG2, default 6: FIFO depth is 2**DEPTH_LOG2 words; legal range 2..10.
REQ-003 Parameter AFULL_TH, default 56: almost-full threshold in words; legal range 1..2**DEPTH_LOG2.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 aclr  input  1  asynchronous, active-high reset.
REQ-006 sclr  input  1  synchronous flush, active-high.
REQ-007 swap_en  input  1  1 = reverse byte order of the read word; 0 = pass through unchanged.
REQ-008 data  input  DATA_W  write word.
REQ-009 wrreq  input  1  write request.
REQ-010 rdreq  input  1  read request.
REQ-011 q  output  DATA_W  registered read word.
REQ-012 rdempty  output  1  FIFO holds zero words.
REQ-013 wrfull  output  1  FIFO holds 2**DEPTH_LOG2 words.
REQ-014 almost_full  output  1  usedw >= AFULL_TH.
REQ-015 usedw  output  DEPTH_LOG2+1  current word count, 0..2**DEPTH_LOG2.
REQ-016 ovf  output  1  sticky overflow flag.
REQ-017 udf  output  1  sticky underflow flag.

Function
REQ-018 A write SHALL be accepted when wrreq=1 and (wrfull=0 or an accepted read occurs in the same cycle); an accepted write stores data at the write pointer and advances the pointer modulo depth.
REQ-019 A read SHALL be accepted when rdreq=1 and rdempty=0; an accepted read loads q on the next clk edge and advances the read pointer modulo depth (read latency 1 cycle).
REQ-020 The byte-swap SHALL be applied when q is loaded, using swap_en sampled in the read cycle: byte i of q = byte (DATA_W/8-1-i) of the stored word; q SHALL hold its value when no read is accepted.
REQ-021 usedw SHALL update on the edge following the requests: +1 for write-only, -1 for read-only, unchanged for simultaneous accepted read and write.
REQ-022 rdempty, wrfull and almost_full SHALL be registered and consistent with usedw in the same cycle.
REQ-023 A write to an empty FIFO SHALL deassert rdempty on the next edge; the word is readable in that cycle.
REQ-024 With rdempty=1 and wrreq=rdreq=1: the write SHALL be accepted, the read ignored, and udf set.
REQ-025 With wrfull=1 and wrreq=rdreq=1: both SHALL be accepted, and usedw SHALL stay at full.
REQ-026 wrreq=1 while wrfull=1 without an accepted read SHALL discard data and set ovf.
REQ-027 rdreq=1 while rdempty=1 SHALL set udf and leave q unchanged.
REQ-028 ovf and udf SHALL clear only on aclr or sclr.
REQ-029 sclr SHALL have priority over wrreq and rdreq: on the next edge, pointers and usedw go to 0, rdempty=1, wrfull=0, almost_full=0, ovf=udf=0, and q is unchanged.

Reset
REQ-030 aclr=1 SHALL immediately force pointers=0, usedw=0, rdempty=1, wrfull=0, almost_full=0, ovf=0, udf=0 and q=0, without waiting for a clk edge.
REQ-031 Storage array contents SHALL NOT be reset; no stale word may be readable after reset.
REQ-032 aclr asserted mid-transfer SHALL discard all in-flight words; the first write after deassertion is the first word read.

Structure
REQ-033 Package pixel_fifo_pkg SHALL hold the parameter-legality checks and a byte-reverse function, so other pixel-path blocks can share them.
REQ-034 Storage SHALL be one sub-module, fifo_pixel_ram: a simple dual-port RAM with synchronous write and synchronous read, DATA_W x 2**DEPTH_LOG2, with no reset; the rest of the block is flag, pointer and count logic.

Verification
REQ-035 Defaults; write 0x0102030405060708 with swap_en=1, then read -> q=0x0807060504030201 one cycle after rdreq, and usedw goes 1 -> 0.
REQ-036 Write 64 words 0..63 with no reads -> wrfull=1, usedw=64, and almost_full first asserts at usedw=56; a 65th write -> ovf=1 and the data is lost; reading 64 words returns 0..63 in order.
REQ-037 From empty, wrreq=rdreq=1 for one cycle -> udf=1, usedw=1, and q is unchanged.
REQ-038 From full, wrreq=rdreq=1 for 10 cycles -> usedw stays 64 and reads return words 0..9.
REQ-039 After 5 writes, pulse sclr -> usedw=0, rdempty=1, ovf=udf=0; then assert aclr asynchronously mid-cycle -> q=0 before the next edge.
REQ-040 Run DATA_W=24, DEPTH_LOG2=2, AFULL_TH=3 with swap_en=0 -> q is bit-identical to data; pointer wrap is exercised over 10 write/read pairs.
